// File: rtl/br_ctrl_pkg.sv
// Shared branch-control defines: widths, FSM encodings, offset helper.
// Imported by the adder, the interface and the controller.
package br_ctrl_pkg;

    localparam int ADDR_W   = 7;
    localparam int OFFSET_W = 6;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    function automatic addr_t sext_off(input offset_t o);
        return {{(ADDR_W-OFFSET_W){o[OFFSET_W-1]}}, o};
    endfunction

endpackage

// File: rtl/br_ctrl_if.sv
// Execute/hazard <-> branch controller bundle.
// master drives branch/stall requests; slave returns pc, flush, state.
interface br_ctrl_if;
    import br_ctrl_pkg::*;

    logic       jump_en_i;
    offset_t    jump_offset_i;
    addr_t      ex_inst_addr_i;
    logic       stall_i;
    addr_t      pc_o;
    logic       flush_o;
    logic [0:0] state_o;

    modport master (
        output jump_en_i, jump_offset_i, ex_inst_addr_i, stall_i,
        input  pc_o, flush_o, state_o
    );

    modport slave (
        input  jump_en_i, jump_offset_i, ex_inst_addr_i, stall_i,
        output pc_o, flush_o, state_o
    );

endinterface

// File: rtl/br_target_add.sv
// Branch target adder: 7-bit base + signed 6-bit offset, modulo 128.
// Ports: base_i, offset_i in; target_o out.
module br_target_add
    import br_ctrl_pkg::*;
(
    input  addr_t   base_i,
    input  offset_t offset_i,
    output addr_t   target_o
);

    assign target_o = base_i + sext_off(offset_i);

endmodule

// File: rtl/br_ctrl.sv
// Branch controller: PC register plus RUN/FLUSH FSM with flush counter.
// Ports: clk, rst_n (async, active-low), bus (br_ctrl_if.slave).
module br_ctrl
    import br_ctrl_pkg::*;
#(
    parameter addr_t RESET_PC     = 7'd0,
    parameter int    FLUSH_CYCLES = 2
) (
    input logic     clk,
    input logic     rst_n,
    br_ctrl_if.slave bus
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    logic [0:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    addr_t      pc_q, pc_d;
    addr_t      target;
    logic       accept;

    br_target_add u_add (
        .base_i   (bus.ex_inst_addr_i),
        .offset_i (bus.jump_offset_i),
        .target_o (target)
    );

    // Branches are only taken in RUN; in FLUSH the EX slot is wrong-path.
    assign accept = (state_q == ST_RUN) && bus.jump_en_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept)
            pc_d = target;
        else if (bus.stall_i)
            pc_d = pc_q;
        else
            pc_d = pc_q + 7'd1;

        if (state_q == ST_RUN) begin
            if (accept && (FLUSH_CYCLES > 1)) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_INIT;
            end
        end else begin
            if (cnt_q == 2'd1) begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    // Gated by rst_n so a request seen during reset cannot raise flush.
    assign bus.flush_o = rst_n & (accept | (state_q == ST_FLUSH));
    assign bus.pc_o    = pc_q;
    assign bus.state_o = state_q;

endmodule

// File: doc/br_ctrl.md
BR_CTRL -- requirements
Module: br_ctrl

Interface
REQ-001 Parameter RESET_PC, default 7'd0: program counter value after reset.
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles flush_o stays asserted per taken branch; legal range 1..3.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 jump_en_i  input  1  taken-branch request from the execute stage.
REQ-006 jump_offset_i  input  6  branch offset from the execute stage, two's-complement signed.
REQ-007 ex_inst_addr_i  input  7  address of the instruction currently in the execute stage.
REQ-008 stall_i  input  1  hold request from the hazard logic.
REQ-009 pc_o  output  7  instruction fetch address, registered.
REQ-010 flush_o  output  1  clear the IF/ID and ID/EX pipeline registers.
REQ-011 state_o  output  1  current FSM state: 0 = RUN, 1 = FLUSH.

Function
REQ-012 Branch target SHALL be ex_inst_addr_i plus sign-extended jump_offset_i, truncated to 7 bits (modulo 128).
REQ-013 Two states SHALL exist, RUN and FLUSH, plus a 2-bit flush counter.
REQ-014 RUN state with jump_en_i=1 (branch accepted): next pc_o = target; stall_i is ignored.
- If FLUSH_CYCLES>1: go to FLUSH, counter = FLUSH_CYCLES-1.
- If FLUSH_CYCLES=1: stay in RUN.
REQ-015 RUN state with jump_en_i=0 and stall_i=1: pc_o SHALL hold.
REQ-016 RUN state with jump_en_i=0 and stall_i=0: pc_o SHALL increment by 1, wrapping 127 -> 0.
REQ-017 flush_o SHALL equal 1 combinationally in the RUN cycle where a branch is accepted, and 1 in every FLUSH cycle; 0 otherwise.
REQ-018 In FLUSH, jump_en_i SHALL be ignored, because the execute stage holds a wrong-path instruction.
REQ-019 In FLUSH, pc_o SHALL follow the stall/increment rules of REQ-015/REQ-016.
REQ-020 In FLUSH, the counter SHALL decrement each cycle; when counter=1, the next state SHALL be RUN.
REQ-021 Branch-accept latency SHALL be one cycle: target appears on pc_o at the edge that samples jump_en_i=1.
REQ-022 A negative offset reaching below 0 SHALL wrap, e.g. 7'd2 + (-4) = 7'd126.
REQ-023 A branch to its own address (offset 0) SHALL be legal; pc_o = ex_inst_addr_i.

Reset
REQ-024 rst_n=0 SHALL immediately set pc_o=RESET_PC, state=RUN, counter=0, and flush_o=0, regardless of clk.
REQ-025 Reset asserted mid-FLUSH SHALL abort the flush; the first cycle after release SHALL be RUN with no flush_o.
REQ-026 After release, the first rising edge SHALL apply normal RUN rules.

Structure
REQ-027 State encodings, ADDR_W=7 and OFFSET_W=6 SHALL live in the shared defines file alongside the opcode defines.
REQ-028 The target adder SHALL be a single sub-module, br_target_add (7-bit base + signed 6-bit offset -> 7-bit).
REQ-029 The FSM and PC register SHALL stay in br_ctrl.

Verification
REQ-030 Reset, then 5 cycles with no stall -> pc_o 0,1,2,3,4,5; flush_o=0 throughout.
REQ-031 pc_o=10, ex_inst_addr_i=8, offset=6'd5, jump_en_i=1 -> next pc_o=13; flush_o=1 for 2 cycles; jump_en_i=1 during the second cycle is ignored.
REQ-032 ex_inst_addr_i=2, offset=6'b111100 (-4), jump_en_i=1 with stall_i=1 -> next pc_o=126, flush_o=1.
REQ-033 pc_o=127, no stall -> next pc_o=0; stall_i=1 for 3 cycles -> pc_o held at 0.
REQ-034 Branch accepted, rst_n pulled low mid-FLUSH -> pc_o=0, flush_o=0 immediately; RUN after release.
REQ-035 FLUSH_CYCLES=1 build: back-to-back jump_en_i on consecutive cycles -> both branches accepted; flush_o=1 in each cycle.
